// File: rtl/keypad_song_sequencer_pkg.sv
// Shared types and helpers for the keypad song sequencer.
// Latency: none (types and pure functions only).
// Backpressure: none.
package keypad_song_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_PLAY  = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    // Next song index, wrapping from the last song back to song 0.
    function automatic logic [15:0] song_wrap_inc(input logic [15:0] s, input int unsigned num_keys);
        return (s == 16'(num_keys - 1)) ? 16'd0 : s + 16'd1;
    endfunction

endpackage

// File: rtl/keypad_song_sequencer_if.sv
// Keypad, button and player-control signals of the song sequencer.
// Latency: none (wiring only).
// Backpressure: none; all events are single-cycle pulses or levels.
interface keypad_song_sequencer_if #(
    parameter int NUM_KEYS = 4,
    parameter int SONG_W   = 2
);
    logic [NUM_KEYS-1:0] key_req;
    logic                play_button;
    logic                next_button;
    logic                song_done;
    logic                play;
    logic                reset_player;
    logic [SONG_W-1:0]   song;

    modport master (
        output key_req, play_button, next_button, song_done,
        input  play, reset_player, song
    );

    modport slave (
        input  key_req, play_button, next_button, song_done,
        output play, reset_player, song
    );
endinterface

// File: rtl/keypad_song_sequencer_key_edge_priority.sv
// Rising-edge detect on key levels with lowest-index-wins selection.
// Latency: key_hit/key_idx are combinational from key_req and the registered history.
// Backpressure: none; extra simultaneous edges are dropped.
module key_edge_priority #(
    parameter int NUM_KEYS = 4,
    parameter int SONG_W   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_req,
    output logic                key_hit,
    output logic [SONG_W-1:0]   key_idx
);
    logic [NUM_KEYS-1:0] key_prev;
    logic [NUM_KEYS-1:0] key_edge;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_prev <= '0;
        end else begin
            key_prev <= key_req;
        end
    end

    assign key_edge = key_req & ~key_prev;

    // Scan high to low so the lowest set edge is the last one written.
    always_comb begin
        key_hit = 1'b0;
        key_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_edge[i]) begin
                key_hit = 1'b1;
                key_idx = SONG_W'(i);
            end
        end
    end
endmodule

// File: rtl/keypad_song_sequencer.sv
// Keypad-driven playback controller: keys select songs, buttons play/pause/next.
// Latency: events sampled at edge n show on play/reset_player/song in cycle n+1.
// Backpressure: none; lower-priority events in the same cycle are dropped.
module keypad_song_sequencer
    import keypad_song_sequencer_pkg::*;
#(
    parameter int NUM_KEYS     = 4,
    parameter int SONG_W       = 2,
    parameter int FLUSH_CYCLES = 4,
    parameter int AUTO_ADVANCE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    keypad_song_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    state_t             state, state_nxt;
    logic [SONG_W-1:0]  song_q, song_nxt, song_inc;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               flush_to_play, flush_to_play_nxt;
    logic               restart;
    logic               cnt_last;
    logic               key_hit;
    logic [SONG_W-1:0]  key_idx;

    key_edge_priority #(
        .NUM_KEYS (NUM_KEYS),
        .SONG_W   (SONG_W)
    ) u_key_edge (
        .clk     (clk),
        .reset   (reset),
        .key_req (bus.key_req),
        .key_hit (key_hit),
        .key_idx (key_idx)
    );

    assign song_inc = SONG_W'(song_wrap_inc(16'(song_q), NUM_KEYS));
    assign cnt_last = (cnt == CNT_W'(FLUSH_CYCLES - 1));

    always_comb begin
        state_nxt         = state;
        song_nxt          = song_q;
        cnt_nxt           = cnt;
        flush_to_play_nxt = flush_to_play;
        restart           = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (key_hit) begin
                    song_nxt          = key_idx;
                    flush_to_play_nxt = 1'b1;
                    restart           = 1'b1;
                end else if (bus.play_button) begin
                    flush_to_play_nxt = 1'b1;
                    restart           = 1'b1;
                end else if (bus.next_button) begin
                    song_nxt = song_inc;
                end
            end
            ST_FLUSH: begin
                if (key_hit) begin
                    song_nxt          = key_idx;
                    flush_to_play_nxt = 1'b1;
                    restart           = 1'b1;
                end else if (cnt_last) begin
                    state_nxt = flush_to_play ? ST_PLAY : ST_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_PLAY: begin
                if (key_hit) begin
                    song_nxt          = key_idx;
                    flush_to_play_nxt = 1'b1;
                    restart           = 1'b1;
                end else if (bus.song_done) begin
                    if (AUTO_ADVANCE != 0) begin
                        song_nxt          = song_inc;
                        flush_to_play_nxt = 1'b1;
                        restart           = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (bus.next_button) begin
                    song_nxt          = song_inc;
                    flush_to_play_nxt = 1'b1;
                    restart           = 1'b1;
                end else if (bus.play_button) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (key_hit) begin
                    song_nxt          = key_idx;
                    flush_to_play_nxt = 1'b1;
                    restart           = 1'b1;
                end else if (bus.play_button) begin
                    state_nxt = ST_PLAY;
                end else if (bus.next_button) begin
                    // Skipping while paused rewinds the player but leaves it stopped.
                    song_nxt          = song_inc;
                    flush_to_play_nxt = 1'b0;
                    restart           = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (restart) begin
            state_nxt = ST_FLUSH;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            song_q        <= '0;
            cnt           <= '0;
            flush_to_play <= 1'b0;
        end else begin
            state         <= state_nxt;
            song_q        <= song_nxt;
            cnt           <= cnt_nxt;
            flush_to_play <= flush_to_play_nxt;
        end
    end

    assign bus.play         = (state == ST_PLAY);
    assign bus.reset_player = (state == ST_FLUSH);
    assign bus.song         = song_q;
endmodule

// File: tb/tb_keypad_song_sequencer.sv
// Scoreboard bench: two sequencers (auto-advance on/off) share random and directed stimulus
// and are compared every cycle against a behavioural playback model.
module tb_keypad_song_sequencer;
    localparam int NK = 4;
    localparam int SW = 2;
    localparam int FC = 4;
    localparam int M_IDLE  = 0;
    localparam int M_FLUSH = 1;
    localparam int M_PLAY  = 2;
    localparam int M_PAUSE = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] key_req = '0;
    logic          play_button = 1'b0;
    logic          next_button = 1'b0;
    logic          song_done = 1'b0;

    always #5 clk = ~clk;

    keypad_song_sequencer_if #(.NUM_KEYS(NK), .SONG_W(SW)) bus_a ();
    keypad_song_sequencer_if #(.NUM_KEYS(NK), .SONG_W(SW)) bus_b ();

    assign bus_a.key_req     = key_req;
    assign bus_a.play_button = play_button;
    assign bus_a.next_button = next_button;
    assign bus_a.song_done   = song_done;
    assign bus_b.key_req     = key_req;
    assign bus_b.play_button = play_button;
    assign bus_b.next_button = next_button;
    assign bus_b.song_done   = song_done;

    keypad_song_sequencer #(.NUM_KEYS(NK), .SONG_W(SW), .FLUSH_CYCLES(FC), .AUTO_ADVANCE(1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    keypad_song_sequencer #(.NUM_KEYS(NK), .SONG_W(SW), .FLUSH_CYCLES(FC), .AUTO_ADVANCE(0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    logic [3:0] exp_a[$];
    logic [3:0] exp_b[$];

    // Reference model, one slot per instance; `left` counts remaining rewind cycles.
    int            m_mode[2];
    int            m_song[2];
    int            m_left[2];
    bit            m_go_play[2];
    logic [NK-1:0] m_prev[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i]    = M_IDLE;
            m_song[i]    = 0;
            m_left[i]    = 0;
            m_go_play[i] = 1'b0;
            m_prev[i]    = '0;
        end
    endfunction

    function automatic void model_rewind(input int i, input int s, input bit go);
        m_song[i]    = s;
        m_mode[i]    = M_FLUSH;
        m_left[i]    = FC;
        m_go_play[i] = go;
    endfunction

    // Returns {play, reset_player, song} expected after the coming clock edge.
    function automatic logic [3:0] model_step(input int i, input bit auto_adv);
        int k = -1;
        int nxt;
        for (int b = 0; b < NK; b++)
            if (key_req[b] && !m_prev[i][b] && k < 0) k = b;
        m_prev[i] = key_req;
        nxt = (m_song[i] + 1) % NK;
        case (m_mode[i])
            M_IDLE: begin
                if (k >= 0)           model_rewind(i, k, 1'b1);
                else if (play_button) model_rewind(i, m_song[i], 1'b1);
                else if (next_button) m_song[i] = nxt;
            end
            M_FLUSH: begin
                if (k >= 0)               model_rewind(i, k, 1'b1);
                else if (m_left[i] == 1)  m_mode[i] = m_go_play[i] ? M_PLAY : M_IDLE;
                else                      m_left[i]--;
            end
            M_PLAY: begin
                if (k >= 0) model_rewind(i, k, 1'b1);
                else if (song_done) begin
                    if (auto_adv) model_rewind(i, nxt, 1'b1);
                    else          m_mode[i] = M_IDLE;
                end
                else if (next_button) model_rewind(i, nxt, 1'b1);
                else if (play_button) m_mode[i] = M_PAUSE;
            end
            default: begin
                if (k >= 0)           model_rewind(i, k, 1'b1);
                else if (play_button) m_mode[i] = M_PLAY;
                else if (next_button) model_rewind(i, nxt, 1'b0);
            end
        endcase
        return {m_mode[i] == M_PLAY, m_mode[i] == M_FLUSH, 2'(m_song[i])};
    endfunction

    task automatic drive(input logic [NK-1:0] k, input logic pb, input logic nb, input logic sd);
        @(negedge clk);
        key_req     = k;
        play_button = pb;
        next_button = nb;
        song_done   = sd;
        exp_a.push_back(model_step(0, 1'b1));
        exp_b.push_back(model_step(1, 1'b0));
    endtask

    task automatic idle(input int n);
        repeat (n) drive(key_req, 1'b0, 1'b0, 1'b0);
    endtask

    // Assert reset away from any clock edge and confirm outputs drop immediately.
    task automatic do_reset(input string tag);
        @(negedge clk);
        mon_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        check({tag, "_a_play"},  32'(bus_a.play), 32'd0);
        check({tag, "_a_rstp"},  32'(bus_a.reset_player), 32'd0);
        check({tag, "_a_song"},  32'(bus_a.song), 32'd0);
        check({tag, "_b_play"},  32'(bus_b.play), 32'd0);
        check({tag, "_b_rstp"},  32'(bus_b.reset_player), 32'd0);
        key_req     = '0;
        play_button = 1'b0;
        next_button = 1'b0;
        song_done   = 1'b0;
        exp_a.delete();
        exp_b.delete();
        model_reset();
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
    endtask

    // Monitor: compares each presented output against the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (exp_a.size() > 0) begin
                    logic [3:0] e;
                    e = exp_a.pop_front();
                    check("auto_obs{play,rstp,song}", 32'({bus_a.play, bus_a.reset_player, bus_a.song}), 32'(e));
                end
                if (exp_b.size() > 0) begin
                    logic [3:0] e;
                    e = exp_b.pop_front();
                    check("stop_obs{play,rstp,song}", 32'({bus_b.play, bus_b.reset_player, bus_b.song}), 32'(e));
                end
            end
        end
    end

    initial begin
        logic [NK-1:0] k;
        model_reset();
        do_reset("por");

        // Key 2 from idle, then held: one rewind only.
        drive(4'b0100, 0, 0, 0);
        idle(20);
        // Two keys at once from play: lowest index wins; re-press of key 3 restarts.
        drive(4'b0000, 0, 0, 0);
        drive(4'b0001, 0, 0, 0);
        idle(6);
        drive(4'b1010, 0, 0, 0);
        idle(6);
        drive(4'b0010, 0, 0, 0);
        drive(4'b1010, 0, 0, 0);
        idle(6);
        // End of song 3 wraps to song 0 (auto) or stops (no auto).
        drive(key_req, 0, 0, 1);
        idle(6);
        // Pause/resume, then skip while paused.
        drive(4'b0000, 0, 0, 0);
        drive(4'b0010, 0, 0, 0);
        idle(6);
        drive(key_req, 1, 0, 0);
        idle(3);
        drive(key_req, 1, 0, 0);
        idle(3);
        drive(key_req, 1, 0, 0);
        drive(key_req, 0, 1, 0);
        idle(6);
        // Key edge during the second rewind cycle extends the rewind.
        drive(4'b0000, 0, 0, 0);
        drive(4'b0010, 0, 0, 0);
        drive(4'b0000, 0, 0, 0);
        drive(4'b0001, 0, 0, 0);
        idle(8);
        // Simultaneous done + next advances once.
        drive(key_req, 0, 1, 1);
        idle(6);
        drive(key_req, 1, 1, 0);
        idle(6);
        do_reset("mid_play");

        for (int n = 0; n < 3000; n++) begin
            k = key_req;
            if ($urandom_range(0, 11) == 0) k[$urandom_range(0, NK - 1)] ^= 1'b1;
            drive(k, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            if (n % 1000 == 999) do_reset("rand_rst");
        end

        idle(2);
        repeat (3) @(negedge clk);
        check("drain_auto", 32'(exp_a.size()), 32'd0);
        check("drain_stop", 32'(exp_b.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
